// File: rtl/light_show_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// light_ctrl_pkg
//   Shared definitions for the light show controller: the display mode
//   encoding (also used on the mode output), the default colour cycle
//   length, and the mode-advance helper used by the mode button.
// ---------------------------------------------------------------------------
package light_ctrl_pkg;

  // Display mode; 2'b11 is unused and never driven.
  typedef enum logic [1:0] {
    MODE_WHITE  = 2'b00,
    MODE_MANUAL = 2'b01,
    MODE_AUTO   = 2'b10
  } mode_t;

  // Length of the selector's colour cycle.
  localparam int DEFAULT_NUM_COLOURS = 6;

  // Mode sequence on each mode button press: WHITE -> MANUAL -> AUTO -> WHITE.
  function automatic mode_t mode_advance(input mode_t cur);
    mode_t nxt;
    case (cur)
      MODE_WHITE:  nxt = MODE_MANUAL;
      MODE_MANUAL: nxt = MODE_AUTO;
      default:     nxt = MODE_WHITE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/light_show_ctrl_if.sv
// ---------------------------------------------------------------------------
// light_show_ctrl_if
//   Bundles the user buttons and the lights-selector control lines.
//   Signals:
//     mode_btn, step_btn : user buttons (synchronous levels)
//     sel                : selector sel, 0 = white, 1 = colour
//     button             : selector button, one-cycle pulse per colour step
//     sel_rst            : selector rst, one-cycle pulse restarting the cycle
//     mode               : current display mode
//     step_idx           : current colour position
//   Modports:
//     master : the controller (reads buttons, drives selector controls)
//     slave  : the environment (drives buttons, observes controls)
// ---------------------------------------------------------------------------
interface light_show_ctrl_if;
  import light_ctrl_pkg::*;

  logic       mode_btn;
  logic       step_btn;
  logic       sel;
  logic       button;
  logic       sel_rst;
  mode_t      mode;
  logic [2:0] step_idx;

  modport master (
    input  mode_btn,
    input  step_btn,
    output sel,
    output button,
    output sel_rst,
    output mode,
    output step_idx
  );

  modport slave (
    output mode_btn,
    output step_btn,
    input  sel,
    input  button,
    input  sel_rst,
    input  mode,
    input  step_idx
  );

endinterface

// File: rtl/light_show_ctrl_edge_pulse.sv
// ---------------------------------------------------------------------------
// edge_pulse
//   Rising-edge detector. rise is high in the cycle where din is 1 and was 0
//   at the previous clock. The history register resets to 0, so an input
//   already high when reset releases is reported as an edge.
//   Ports:
//     clk  : system clock
//     rst  : asynchronous active-high reset
//     din  : synchronous input level
//     rise : combinational edge indication, to be registered by the user
// ---------------------------------------------------------------------------
module edge_pulse (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic rise
);

  logic hist_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_reg <= 1'b0;
    end else begin
      hist_reg <= din;
    end
  end

  assign rise = din & ~hist_reg;

endmodule

// File: rtl/light_show_ctrl.sv
// ---------------------------------------------------------------------------
// light_show_ctrl
//   Mode and step controller for the lights selector. Two user buttons are
//   turned into three display modes (WHITE, MANUAL, AUTO); the block owns
//   the selector's sel, button and rst inputs. All outputs are registered.
//   Ports:
//     clk : system clock, rising edge
//     rst : asynchronous active-high reset
//     bus : light_show_ctrl_if.master (buttons in, selector controls out)
//   Parameters:
//     STEP_CYCLES  : cycles between automatic steps in AUTO (>= 2)
//     IDLE_TIMEOUT : idle cycles in MANUAL before falling back to WHITE (>= 2)
//     NUM_COLOURS  : colour cycle length; step_idx wraps at this value
// ---------------------------------------------------------------------------
module light_show_ctrl
  import light_ctrl_pkg::*;
#(
  parameter int STEP_CYCLES  = 8,
  parameter int IDLE_TIMEOUT = 64,
  parameter int NUM_COLOURS  = DEFAULT_NUM_COLOURS
) (
  input logic               clk,
  input logic               rst,
  light_show_ctrl_if.master bus
);

  localparam int TICK_W = $clog2(STEP_CYCLES);
  localparam int IDLE_W = $clog2(IDLE_TIMEOUT);

  localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(STEP_CYCLES - 1);
  localparam logic [IDLE_W-1:0] IDLE_LAST = IDLE_W'(IDLE_TIMEOUT - 1);
  localparam logic [2:0]        IDX_LAST  = 3'(NUM_COLOURS - 1);

  // ---------------------------------------------------------------------
  // Button edge detection: bit 0 = mode_btn, bit 1 = step_btn
  // ---------------------------------------------------------------------
  logic [1:0] btn_raw;
  logic [1:0] btn_rise;
  logic       mode_rise;
  logic       step_rise;

  assign btn_raw = {bus.step_btn, bus.mode_btn};

  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_edge
      edge_pulse u_edge (
        .clk  (clk),
        .rst  (rst),
        .din  (btn_raw[gi]),
        .rise (btn_rise[gi])
      );
    end
  endgenerate

  assign mode_rise = btn_rise[0];
  assign step_rise = btn_rise[1];

  // ---------------------------------------------------------------------
  // State and output registers
  // ---------------------------------------------------------------------
  mode_t             mode_reg,     mode_next;
  logic              sel_reg,      sel_next;
  logic              button_reg,   button_next;
  logic              sel_rst_reg,  sel_rst_next;
  logic [2:0]        step_idx_reg, step_idx_next;
  logic [TICK_W-1:0] tick_cnt_reg, tick_cnt_next;
  logic [IDLE_W-1:0] idle_cnt_reg, idle_cnt_next;
  logic [2:0]        step_idx_inc;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mode_reg     <= MODE_WHITE;
      sel_reg      <= 1'b0;
      button_reg   <= 1'b0;
      sel_rst_reg  <= 1'b0;
      step_idx_reg <= '0;
      tick_cnt_reg <= '0;
      idle_cnt_reg <= '0;
    end else begin
      mode_reg     <= mode_next;
      sel_reg      <= sel_next;
      button_reg   <= button_next;
      sel_rst_reg  <= sel_rst_next;
      step_idx_reg <= step_idx_next;
      tick_cnt_reg <= tick_cnt_next;
      idle_cnt_reg <= idle_cnt_next;
    end
  end

  // Wrap compares against the last index so step_idx never reaches NUM_COLOURS.
  assign step_idx_inc = (step_idx_reg == IDX_LAST) ? 3'd0 : step_idx_reg + 3'd1;

  // ---------------------------------------------------------------------
  // Next-state / output logic
  // ---------------------------------------------------------------------
  always_comb begin
    mode_next     = mode_reg;
    sel_next      = sel_reg;
    button_next   = 1'b0;
    sel_rst_next  = 1'b0;
    step_idx_next = step_idx_reg;
    tick_cnt_next = tick_cnt_reg;
    idle_cnt_next = idle_cnt_reg;

    if (mode_rise) begin
      // A mode press wins over a step press or timer tick in the same
      // cycle; that step is dropped, which also keeps sel_rst and button
      // mutually exclusive.
      mode_next     = mode_advance(mode_reg);
      tick_cnt_next = '0;
      idle_cnt_next = '0;
      if (mode_next != MODE_WHITE) begin
        sel_rst_next  = 1'b1;
        step_idx_next = '0;
      end
    end else begin
      case (mode_reg)
        MODE_MANUAL: begin
          // A step press on the would-be timeout clock cancels the timeout.
          if (step_rise) begin
            button_next   = 1'b1;
            step_idx_next = step_idx_inc;
            idle_cnt_next = '0;
          end else if (idle_cnt_reg == IDLE_LAST) begin
            mode_next     = MODE_WHITE;
            idle_cnt_next = '0;
          end else begin
            idle_cnt_next = idle_cnt_reg + 1'b1;
          end
        end
        MODE_AUTO: begin
          if (tick_cnt_reg == TICK_LAST) begin
            tick_cnt_next = '0;
            button_next   = 1'b1;
            step_idx_next = step_idx_inc;
          end else begin
            tick_cnt_next = tick_cnt_reg + 1'b1;
          end
        end
        default: begin
          // WHITE: step presses ignored, step_idx holds.
        end
      endcase
    end

    // sel follows the mode that is being loaded this cycle.
    sel_next = (mode_next != MODE_WHITE);
  end

  assign bus.mode     = mode_reg;
  assign bus.sel      = sel_reg;
  assign bus.button   = button_reg;
  assign bus.sel_rst  = sel_rst_reg;
  assign bus.step_idx = step_idx_reg;

endmodule
